// File: rtl/interp_fir_stream.sv
// Streaming 8-tap fractional-phase interpolation FIR with valid/ready handshake.
// A sliding window of the current line feeds a two-stage arithmetic pipeline
// (partial sums, then round/shift/saturate into the output register).
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid/in_ready    input handshake (in_ready = !stall, combinational)
//   in_data              signed sample, DATA_WIDTH+2 bits
//   in_first/in_last     line delimiters; in_frac phase latched with in_first
//   out_valid/out_ready  output handshake
//   out_data/out_last    filtered sample and end-of-line marker
//   err_short            sticky flag: a line ended with fewer than 8 samples
module interp_fir_stream #(
  parameter int DATA_WIDTH = 8,
  parameter int OUT_W      = DATA_WIDTH + 2,
  parameter int SHIFT      = 6
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic signed [DATA_WIDTH+1:0]  in_data,
  input  logic                          in_first,
  input  logic                          in_last,
  input  logic [1:0]                    in_frac,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic signed [OUT_W-1:0]       out_data,
  output logic                          out_last,
  output logic                          err_short
);

  localparam int unsigned IW    = DATA_WIDTH + 2;
  localparam int unsigned ACC_W = IW + 8;
  localparam int unsigned NTAP  = 8;

  localparam logic signed [ACC_W-1:0] RND    = ACC_W'(1) <<< (SHIFT - 1);
  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'((2 ** (OUT_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_LO = ~SAT_HI;

  // Tap sets indexed by window position w0..w7; unused taps are zero.
  localparam logic signed [7:0] C_Q [NTAP] = '{-8'sd1, 8'sd4, -8'sd10, 8'sd58,
                                               8'sd17, -8'sd5, 8'sd1, 8'sd0};
  localparam logic signed [7:0] C_H [NTAP] = '{-8'sd1, 8'sd4, -8'sd11, 8'sd40,
                                               8'sd40, -8'sd11, 8'sd4, -8'sd1};
  localparam logic signed [7:0] C_T [NTAP] = '{8'sd0, 8'sd1, -8'sd5, 8'sd17,
                                               8'sd58, -8'sd10, 8'sd4, -8'sd1};

  function automatic logic signed [7:0] coef(input logic [1:0] ph, input logic [2:0] idx);
    case (ph)
      2'd1:    coef = C_Q[idx];
      2'd2:    coef = C_H[idx];
      2'd3:    coef = C_T[idx];
      default: coef = 8'sd0;
    endcase
  endfunction

  logic signed [IW-1:0]    win_q [NTAP];
  logic signed [IW-1:0]    win_d [NTAP];
  logic [3:0]              fill_q, fill_d;
  logic [1:0]              phase_q, phase_d;
  logic                    wv_q, wv_d, wl_q, wl_d;
  logic signed [ACC_W-1:0] lo_q, lo_d, hi_q, hi_d;
  logic                    s1v_q, s1v_d, s1l_q, s1l_d;
  logic signed [OUT_W-1:0] out_data_q, out_data_d;
  logic                    out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic                    err_q, err_d;

  logic                    stall;
  logic                    start;
  logic [3:0]              fill_nx;
  logic signed [ACC_W-1:0] lo_c, hi_c, sum_c, shr_c;
  logic signed [OUT_W-1:0] sat_c;

  // Partial sums of the lower (w0..w3) and upper (w4..w7) window halves.
  always_comb begin
    lo_c = '0;
    hi_c = '0;
    if (phase_q == 2'd0) begin
      lo_c = ACC_W'(win_q[3]) <<< SHIFT;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (i < 4) lo_c = lo_c + ACC_W'(win_q[3'(i)]) * ACC_W'(coef(phase_q, 3'(i)));
        else       hi_c = hi_c + ACC_W'(win_q[3'(i)]) * ACC_W'(coef(phase_q, 3'(i)));
      end
    end
  end

  // Round to nearest (half up), arithmetic shift, clamp to the output range.
  always_comb begin
    sum_c = lo_q + hi_q + RND;
    shr_c = sum_c >>> SHIFT;
    if (shr_c > SAT_HI)      sat_c = {1'b0, {(OUT_W-1){1'b1}}};
    else if (shr_c < SAT_LO) sat_c = {1'b1, {(OUT_W-1){1'b0}}};
    else                     sat_c = OUT_W'(shr_c);
  end

  assign stall    = out_valid_q && !out_ready;
  assign in_ready = !stall;

  // Next-state: everything freezes while the output is stalled.
  always_comb begin
    win_d       = win_q;
    fill_d      = fill_q;
    phase_d     = phase_q;
    wv_d        = wv_q;
    wl_d        = wl_q;
    lo_d        = lo_q;
    hi_d        = hi_q;
    s1v_d       = s1v_q;
    s1l_d       = s1l_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    err_d       = err_q;
    start       = 1'b0;
    fill_nx     = fill_q;

    if (!stall) begin
      wv_d = 1'b0;
      wl_d = 1'b0;
      if (in_valid) begin
        // A line starts on in_first or on the first sample after in_last.
        start   = in_first || (fill_q == 4'd0);
        fill_nx = start ? 4'd1 : ((fill_q == 4'd8) ? 4'd8 : fill_q + 4'd1);
        for (int i = 0; i < 7; i++) win_d[i] = start ? '0 : win_q[i+1];
        win_d[7] = in_data;
        if (in_first) phase_d = in_frac;
        wv_d = (fill_nx == 4'd8);
        wl_d = in_last && (fill_nx == 4'd8);
        if (in_last) begin
          if (fill_nx != 4'd8) err_d = 1'b1;
          fill_d = 4'd0;
        end else begin
          fill_d = fill_nx;
        end
      end

      s1v_d = wv_q;
      s1l_d = wl_q;
      lo_d  = lo_c;
      hi_d  = hi_c;

      out_valid_d = s1v_q;
      out_last_d  = s1l_q;
      if (s1v_q) out_data_d = sat_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) win_q[i] <= '0;
      fill_q      <= '0;
      phase_q     <= '0;
      wv_q        <= 1'b0;
      wl_q        <= 1'b0;
      lo_q        <= '0;
      hi_q        <= '0;
      s1v_q       <= 1'b0;
      s1l_q       <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      win_q       <= win_d;
      fill_q      <= fill_d;
      phase_q     <= phase_d;
      wv_q        <= wv_d;
      wl_q        <= wl_d;
      lo_q        <= lo_d;
      hi_q        <= hi_d;
      s1v_q       <= s1v_d;
      s1l_q       <= s1l_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      err_q       <= err_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign err_short = err_q;

endmodule

// File: tb/tb_interp_fir_stream.sv
// Directed bench for interp_fir_stream: table of single-output lines plus
// hand-written sequences for stall, restart, short-line and reset cases.
module tb_interp_fir_stream;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid, in_ready, in_first, in_last;
  logic signed [9:0] in_data;
  logic [1:0]        in_frac;
  logic              out_valid, out_ready, out_last, err_short;
  logic signed [9:0] out_data;

  interp_fir_stream dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_first(in_first), .in_last(in_last), .in_frac(in_frac),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .err_short(err_short)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]       frac;
    logic [7:0][9:0]  s;
    logic signed [9:0] exp;
  } vec_t;

  vec_t tv [8];
  int   line_buf [16];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   acc_edge = 0;

  // Monitor-owned state
  int   got_d [$];
  int   got_l [$];
  int   got_c [$];
  int   inv_bad = 0;
  int   stall_cnt = 0;
  bit   prev_stall = 0;
  int   prev_d = 0;
  bit   prev_l = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Capture transfers and check the stall/in_ready relation and output hold.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        got_d.push_back(int'(out_data));
        got_l.push_back(int'(out_last));
        got_c.push_back(cyc);
      end
      if (in_ready !== !(out_valid && !out_ready)) inv_bad++;
      if (prev_stall && (out_valid !== 1'b1 || int'(out_data) != prev_d || out_last !== prev_l))
        inv_bad++;
      if (out_valid && !out_ready) stall_cnt++;
      prev_stall = out_valid && !out_ready;
      prev_d     = int'(out_data);
      prev_l     = out_last;
    end else begin
      prev_stall = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic set_vec(input int k, input logic [1:0] f, input int a0, input int a1,
                         input int a2, input int a3, input int a4, input int a5,
                         input int a6, input int a7, input int e);
    tv[k].frac = f;
    tv[k].s[0] = 10'(a0); tv[k].s[1] = 10'(a1); tv[k].s[2] = 10'(a2); tv[k].s[3] = 10'(a3);
    tv[k].s[4] = 10'(a4); tv[k].s[5] = 10'(a5); tv[k].s[6] = 10'(a6); tv[k].s[7] = 10'(a7);
    tv[k].exp  = 10'(e);
  endtask

  // Present line_buf[0..n-1] back to back; returns with the last sample on the bus.
  task automatic send_line(input logic [1:0] frac, input int n, input bit f, input bit l);
    int g;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 10'(line_buf[i]);
      in_first = f && (i == 0);
      in_last  = l && (i == n - 1);
      in_frac  = frac;
      g = 0;
      while (!in_ready && g < 200) begin
        @(negedge clk);
        g++;
      end
      if (g >= 200) chk("in_ready_timeout", 0, 1);
      acc_edge = cyc + 1;
    end
  endtask

  task automatic end_tx();
    @(negedge clk);
    in_valid = 1'b0;
    in_first = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic stall_ctrl();
    int g;
    g = 0;
    @(negedge clk);
    while (!out_valid && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (g >= 100) chk("stall_wait_timeout", 0, 1);
    @(posedge clk); #1 out_ready = 1'b0;
    repeat (5) @(posedge clk);
    #1 out_ready = 1'b1;
  endtask

  task automatic do_reset(input string tag);
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    chk({tag, "_async_valid"}, int'(out_valid), 0);
    chk({tag, "_async_data"}, int'(out_data), 0);
    chk({tag, "_async_err"}, int'(err_short), 0);
    repeat (3) begin
      @(negedge clk);
      chk({tag, "_rst_valid"}, int'(out_valid), 0);
      chk({tag, "_rst_data"}, int'(out_data), 0);
    end
    @(posedge clk); #2 rst_n = 1'b1;
    @(negedge clk);
    chk({tag, "_in_ready_after_rst"}, int'(in_ready), 1);
  endtask

  initial begin
    int base;
    int s0;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_first = 1'b0; in_last = 1'b0;
    in_frac = 2'd0; out_ready = 1'b1;

    set_vec(0, 2'd1, 100, 100, 100, 100, 100, 100, 100, 100, 100);
    set_vec(1, 2'd1, 0, 0, 0, 64, 0, 0, 0, 0, 58);
    set_vec(2, 2'd2, -512, 511, -512, 511, 511, -512, 511, -512, 511);
    set_vec(3, 2'd0, 1, 2, 3, 4, 5, 6, 7, 8, 4);
    set_vec(4, 2'd3, -100, -100, -100, -100, -100, -100, -100, -100, -100);
    set_vec(5, 2'd2, 511, -512, 511, -512, -512, 511, -512, 511, -512);
    set_vec(6, 2'd1, 0, 0, 0, 0, 3, 0, 0, 0, 1);
    set_vec(7, 2'd2, 10, 10, 10, 10, 10, 10, 10, 10, 10);

    repeat (2) @(negedge clk);
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_out_data", int'(out_data), 0);
    chk("reset_out_last", int'(out_last), 0);
    chk("reset_err_short", int'(err_short), 0);
    @(posedge clk); #2 rst_n = 1'b1;
    @(negedge clk);
    chk("in_ready_after_reset", int'(in_ready), 1);

    // Single-output 8-sample lines
    for (int k = 0; k < 8; k++) begin
      base = got_d.size();
      for (int i = 0; i < 8; i++) line_buf[i] = int'($signed(tv[k].s[i]));
      send_line(tv[k].frac, 8, 1'b1, 1'b1);
      end_tx();
      repeat (6) @(negedge clk);
      chk($sformatf("vec%0d_count", k), got_d.size() - base, 1);
      if (got_d.size() > base) begin
        chk($sformatf("vec%0d_data", k), got_d[base], int'(tv[k].exp));
        chk($sformatf("vec%0d_last", k), got_l[base], 1);
        chk($sformatf("vec%0d_latency", k), got_c[base] - acc_edge, 2);
      end
    end

    // Restart mid-stream: 9-sample open line, then a new line right behind it
    base = got_d.size();
    for (int i = 0; i < 9; i++) line_buf[i] = 100;
    send_line(2'd1, 9, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) line_buf[i] = 50;
    send_line(2'd1, 8, 1'b1, 1'b1);
    end_tx();
    repeat (6) @(negedge clk);
    chk("restart_count", got_d.size() - base, 3);
    if (got_d.size() >= base + 3) begin
      chk("restart_d0", got_d[base], 100);
      chk("restart_d1", got_d[base+1], 100);
      chk("restart_d2", got_d[base+2], 50);
      chk("restart_l0", got_l[base], 0);
      chk("restart_l1", got_l[base+1], 0);
      chk("restart_l2", got_l[base+2], 1);
    end

    // 12-sample ramp, three-quarter phase, with a 5-cycle downstream stall
    base = got_d.size();
    s0 = stall_cnt;
    for (int i = 0; i < 12; i++) line_buf[i] = 10 * i;
    fork
      send_line(2'd3, 12, 1'b1, 1'b1);
      stall_ctrl();
    join
    end_tx();
    repeat (10) @(negedge clk);
    chk("ramp_count", got_d.size() - base, 5);
    chk("ramp_stall_cycles", stall_cnt - s0, 5);
    if (got_d.size() >= base + 5) begin
      chk("ramp_d0", got_d[base], 38);
      chk("ramp_d1", got_d[base+1], 48);
      chk("ramp_d2", got_d[base+2], 58);
      chk("ramp_d3", got_d[base+3], 68);
      chk("ramp_d4", got_d[base+4], 78);
      chk("ramp_last_mid", got_l[base] + got_l[base+1] + got_l[base+2] + got_l[base+3], 0);
      chk("ramp_last_end", got_l[base+4], 1);
    end

    // Short line sets sticky error; next line starts without in_first
    chk("err_before_short", int'(err_short), 0);
    base = got_d.size();
    for (int i = 0; i < 4; i++) line_buf[i] = 7;
    send_line(2'd1, 4, 1'b1, 1'b1);
    end_tx();
    repeat (4) @(negedge clk);
    chk("short_no_output", got_d.size() - base, 0);
    chk("short_err_set", int'(err_short), 1);
    for (int i = 0; i < 8; i++) line_buf[i] = 100;
    send_line(2'd2, 8, 1'b0, 1'b1);
    end_tx();
    repeat (6) @(negedge clk);
    chk("after_short_count", got_d.size() - base, 1);
    if (got_d.size() > base) begin
      chk("after_short_data", got_d[base], 100);
      chk("after_short_last", got_l[base], 1);
    end
    chk("err_sticky", int'(err_short), 1);

    // Reset clears error and a partial line; phase returns to integer
    for (int i = 0; i < 5; i++) line_buf[i] = 9;
    send_line(2'd1, 5, 1'b1, 1'b0);
    end_tx();
    do_reset("midline");
    chk("err_cleared", int'(err_short), 0);
    base = got_d.size();
    for (int i = 0; i < 8; i++) line_buf[i] = i + 1;
    send_line(2'd1, 8, 1'b0, 1'b1);
    end_tx();
    repeat (6) @(negedge clk);
    chk("post_reset_count", got_d.size() - base, 1);
    if (got_d.size() > base) begin
      chk("post_reset_data", got_d[base], 4);
      chk("post_reset_last", got_l[base], 1);
    end

    chk("stall_invariant_violations", inv_bad, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/interp_fir_stream.md
INTERP_FIR_STREAM -- requirements
Module: interp_fir_stream

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, base sample width; samples are DATA_WIDTH+2 bits signed (IW).
REQ-002 SHALL have parameter OUT_W, default DATA_WIDTH+2, signed output width after saturation.
REQ-003 SHALL have parameter SHIFT, default 6, arithmetic right-shift applied after rounding.
REQ-004 SHALL have a single clock and an asynchronous active-low reset, named as below.
REQ-005 SHALL have ports:
  clk  in  1  rising-edge clock
  rst_n  in  1  asynchronous active-low reset
  in_valid  in  1  input sample valid
  in_ready  out  1  block accepts input this cycle
  in_data  in  IW  signed input sample
  in_first  in  1  sample is first of a line
  in_last  in  1  sample is last of a line
  in_frac  in  2  phase, sampled with in_first: 0 integer, 1 quarter, 2 half, 3 three-quarter
  out_valid  out  1  output valid
  out_ready  in  1  downstream accepts output
  out_data  out  OUT_W  signed filtered sample
  out_last  out  1  output is last of its line
  err_short  out  1  sticky: a line ended before 8 samples

Function
REQ-006 SHALL accept a sample on a rising edge where in_valid && in_ready.
REQ-007 SHALL keep an 8-entry window w0 (oldest) .. w7 (newest); each accepted sample shifts in at w7.
REQ-008 SHALL keep a fill counter 0..8, saturating at 8; accepted in_first sets fill to 1 and discards the previous window content.
REQ-009 SHALL latch in_frac into a line phase register on accepted in_first; other samples in the line use the latched phase.
REQ-010 SHALL issue one output per accepted sample that leaves fill == 8; a line of N >= 8 samples yields N-7 outputs.
REQ-011 SHALL compute the accumulator at IW+8 bits signed for each phase:
  - quarter: -1,4,-10,58,17,-5,1 on w0..w6
  - half: -1,4,-11,40,40,-11,4,-1 on w0..w7
  - three-quarter: 1,-5,17,58,-10,4,-1 on w1..w7
  - integer: w3 << SHIFT
REQ-012 SHALL form the result as (acc + 2^(SHIFT-1)) >>> SHIFT, then saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
REQ-013 SHALL have two pipeline register stages after the window: stage 1 holds partial sums, stage 2 is the output register.
REQ-014 SHALL make the output for a sample accepted at edge k visible on out_data/out_valid after edge k+2, absent stalls.
REQ-015 SHALL define stall = out_valid && !out_ready; while stall is high, in_ready = 0 and no window, fill or pipeline register changes.
REQ-016 SHALL drive in_ready = !stall combinationally; bubbles propagate as cleared stage-valid bits.
REQ-017 SHALL hold out_data, out_last and out_valid stable while stall is high.
REQ-018 SHALL set out_last on the output produced by the accepted sample carrying in_last.
REQ-019 SHALL reset fill to 0 after an accepted in_last, so the next sample starts a new line whether or not in_first is set.
REQ-020 SHALL set err_short when in_last is accepted with resulting fill < 8, including in_first && in_last on one sample; such a line produces no output.
REQ-021 SHALL let outputs already in stages 1-2 complete normally when in_first restarts a line.

Reset
REQ-022 SHALL, while rst_n is low, force out_valid=0, out_data=0, out_last=0, err_short=0, fill=0, window=0, stage valids=0 and phase=0, independent of clk.
REQ-023 SHALL drive in_ready=1 from the first cycle after rst_n is released; in-flight data is discarded by reset.

Verification
REQ-024 Quarter phase, 8 samples of constant 100 -> exactly one output, 100, with out_last on the 8th sample.
REQ-025 Quarter phase, samples 0,0,0,64,0,0,0,0 -> output 58, two edges after the 8th sample is accepted.
REQ-026 Half phase, samples -512,511,-512,511,511,-512,511,-512 -> unsaturated 895, output 511 (saturated).
REQ-027 12-sample ramp, three-quarter phase, out_ready held low for 5 cycles mid-line -> 5 outputs in order, none lost or duplicated, in_ready low exactly while stall is high, out_last only on the 5th.
REQ-028 4-sample line with in_last -> no output, err_short=1 and held until reset; a following 8-sample line still yields 1 output.
REQ-029 rst_n pulsed low after 5 samples of a line, then a fresh 8-sample line -> all outputs 0 during reset, exactly one output afterwards.
